rr_req_agent: RTL

Requester-side front end for the round-robin arbiter: it accepts burst transactions from N clients, drives the arbiter's `req` vector, consumes `grant`/`grant_valid`, and sequences the winning client's burst on a shared bus. It sits between the client blocks and the arbiter. It guarantees that only one burst owns the bus at a time, and it flags arbiter protocol violations.

---
 rtl/rr_req_agent.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rr_req_agent.sv
// rtl/rr_req_agent.sv - requester front end for the round-robin arbiter
// Optional starvation counters: define RR_AGENT_TIMEOUT_EN.
module rr_req_agent #(
    parameter int N       = 4,
    parameter int LW      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         cl_valid,
    input  logic [N*LW-1:0]      cl_len,
    output logic [N-1:0]         cl_ready,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         grant,
    input  logic                 grant_valid,
    output logic                 bus_valid,
    output logic [$clog2(N)-1:0] bus_owner,
    output logic [LW-1:0]        bus_beat,
    output logic                 bus_last,
    output logic [N-1:0]         done,
    output logic                 err,
    output logic [N-1:0]         starve
);

    localparam int OW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER
    } state_t;

    state_t        state [N];
    logic [LW-1:0] len_q [N];

    logic [N-1:0]  pend;
    logic [N-1:0]  pend_nxt;
    logic [N-1:0]  accept;
    logic          busy;
    logic          busy_nxt;
    logic          grant_onehot;
    logic          grant_bad;
    logic          take;
    logic          burst_end;
    logic [OW-1:0] grant_idx;
    logic [LW-1:0] beat_inc;

    // The bus being occupied is exactly the "busy" condition.
    assign busy      = bus_valid;
    assign accept    = cl_valid & cl_ready;
    assign burst_end = bus_valid & bus_last;
    assign beat_inc  = bus_beat + LW'(1);

    assign grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    // A malformed grant is flagged even during a burst; a well-formed grant during a burst is simply ignored.
    assign grant_bad = grant_valid & (~grant_onehot | (~busy & ((grant & pend) == '0)));
    assign take      = grant_valid & grant_onehot & ~busy & ((grant & pend) != '0);

    // Pending flags, grant index and next-cycle bus lock used to register req.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = (state[i] == S_REQ);
            if (grant[i]) grant_idx = OW'(i);
        end
        pend_nxt = (pend & ~(grant & {N{take}})) | accept;
        busy_nxt = take | (busy & ~burst_end);
    end

    // Per-client FSMs, bus sequencer and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= S_IDLE;
                len_q[i] <= '0;
            end
            cl_ready  <= '1;
            req       <= '0;
            bus_valid <= 1'b0;
            bus_owner <= '0;
            bus_beat  <= '0;
            bus_last  <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (state[i])
                    S_IDLE: begin
                        if (accept[i]) begin
                            state[i]    <= S_REQ;
                            len_q[i]    <= cl_len[i*LW +: LW];
                            cl_ready[i] <= 1'b0;
                        end
                    end
                    S_REQ: begin
                        if (take && grant[i]) state[i] <= S_XFER;
                    end
                    S_XFER: begin
                        if (burst_end) begin
                            state[i]    <= S_IDLE;
                            cl_ready[i] <= 1'b1;
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end

            // Requests are suppressed while the bus is (or is about to be) owned.
            req  <= pend_nxt & {N{~busy_nxt}};
            done <= '0;

            if (take) begin
                bus_valid <= 1'b1;
                bus_owner <= grant_idx;
                bus_beat  <= '0;
                bus_last  <= (len_q[grant_idx] == '0);
                done      <= (len_q[grant_idx] == '0) ? grant : '0;
            end else if (bus_valid) begin
                if (bus_last) begin
                    bus_valid <= 1'b0;
                    bus_last  <= 1'b0;
                    bus_beat  <= '0;
                end else begin
                    bus_beat <= beat_inc;
                    bus_last <= (beat_inc == len_q[bus_owner]);
                    done     <= (beat_inc == len_q[bus_owner]) ? (N'(1) << bus_owner) : '0;
                end
            end

            if (grant_bad) err <= 1'b1;
        end
    end

`ifdef RR_AGENT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt [N];

    // Count cycles a client stays in REQ; pulse starve each TIMEOUT cycles and restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
            starve <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && pend_nxt[i]) begin
                    if (wait_cnt[i] == CW'(TIMEOUT - 1)) begin
                        wait_cnt[i] <= '0;
                        starve[i]   <= 1'b1;
                    end else begin
                        wait_cnt[i] <= wait_cnt[i] + CW'(1);
                        starve[i]   <= 1'b0;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                    starve[i]   <= 1'b0;
                end
            end
        end
    end
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT > 0);
    assign starve         = '0;
`endif

endmodule
